// File: rtl/decoder3x8_reg.sv
// Registered 3-to-8 decoder: one-hot B, a valid flag and the select code, one clock after sampling.
// Defining DECODER_ACTIVE_LOW_EN makes B one-cold, idling at 8'hFF; valid and sel_q are unchanged.
module decoder3x8_reg #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  A,
    output logic [OUT_W-1:0] B,
    output logic             valid,
    output logic [IN_W-1:0]  sel_q
);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] B_IDLE = '1;
`else
    localparam logic [OUT_W-1:0] B_IDLE = '0;
`endif

    logic [OUT_W-1:0] b_d, b_q;
    logic             valid_d, valid_q;
    logic [IN_W-1:0]  sel_d, sel_reg_q;
    logic [OUT_W-1:0] onehot;
    logic             a_known;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (A == IN_W'(i));
        end
    end

    // X/Z on A must never reach B as a multi-hot word; synthesis sees A as 2-state.
`ifndef SYNTHESIS
    assign a_known = !$isunknown(A);
`else
    assign a_known = 1'b1;
`endif

    always_comb begin
        b_d     = B_IDLE;
        valid_d = 1'b0;
        sel_d   = sel_reg_q;
        if (en && a_known) begin
`ifdef DECODER_ACTIVE_LOW_EN
            b_d = ~onehot;
`else
            b_d = onehot;
`endif
            valid_d = 1'b1;
            sel_d   = A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q       <= B_IDLE;
            valid_q   <= 1'b0;
            sel_reg_q <= '0;
        end else begin
            b_q       <= b_d;
            valid_q   <= valid_d;
            sel_reg_q <= sel_d;
        end
    end

    assign B     = b_q;
    assign valid = valid_q;
    assign sel_q = sel_reg_q;

endmodule

// File: tb/tb_decoder3x8_reg.sv
// Scoreboard bench for decoder3x8_reg: the driver pushes the expected registered outputs for every
// edge, and a monitor pops and compares one entry per clock.
module tb_decoder3x8_reg;

    typedef struct {
        logic [7:0] b;
        logic       valid;
        logic [2:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] A;
    logic [7:0] B;
    logic       valid;
    logic [2:0] sel_q;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_sel  = 0;
    bit   drv_done = 1'b0;

    decoder3x8_reg dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .A     (A),
        .B     (B),
        .valid (valid),
        .sel_q (sel_q)
    );

    always #5 clk = ~clk;

    // Reference model: what the registered outputs must show after the coming edge.
    function automatic exp_t model(input bit r, input bit e, input int a);
        exp_t x;
        int   word;
        if (r) begin
            word  = 0;
            m_sel = 0;
            x.valid = 1'b0;
        end else if (e) begin
            word  = 2 ** a;
            m_sel = a;
            x.valid = 1'b1;
        end else begin
            word  = 0;
            x.valid = 1'b0;
        end
`ifdef DECODER_ACTIVE_LOW_EN
        word = 255 - word;
`endif
        x.b   = word[7:0];
        x.sel = m_sel[2:0];
        return x;
    endfunction

    task automatic step(input bit r, input bit e, input int a, input int n);
        for (int k = 0; k < n; k++) begin
            rst = r;
            en  = e;
            A   = a[2:0];
            q.push_back(model(r, e, a));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t e;
        int   hot;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("B", int'(B), int'(e.b));
                check("valid", int'(valid), int'(e.valid));
                check("sel_q", int'(sel_q), int'(e.sel));
`ifdef DECODER_ACTIVE_LOW_EN
                hot = $countones(~B);
`else
                hot = $countones(B);
`endif
                check("onehot_invariant", int'(hot == (valid ? 1 : 0)), 1);
            end
        end
    end

    initial begin
        // reset held with en=1, A=5, then first decode
        step(1, 1, 5, 2);
        step(0, 1, 5, 1);
        // sweep twice, each value held for 50 ns
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 8; a++)
                step(0, 1, a, 5);
        // back-to-back
        step(0, 1, 3, 1);
        step(0, 1, 6, 1);
        step(0, 1, 0, 1);
        step(0, 1, 7, 1);
        // disable after A=4, then re-enable with A=2
        step(0, 1, 4, 1);
        step(0, 0, 6, 2);
        step(0, 1, 2, 1);
        // mid-operation reset pulse
        step(0, 1, 7, 1);
        step(1, 1, 7, 1);
        step(0, 1, 7, 1);
        // randomized traffic
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), 1);
        drv_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100 us");
        $fatal(1, "timeout");
    end

endmodule
